register_writeback_file: RTL and testbench

- Architectural register file sitting directly downstream of the register-data arbitrator.
- Each cycle it consumes the arbitrated 16-bit write-back word together with a write strobe and a destination address, then commits the word into one of 16 registers.
- It also provides two registered read ports for the decode/operand stage.
- A per-register pending-write scoreboard raises a combinational stall while an operand still has an outstanding write, unless that write can be forwarded.

---
 rtl/cpu_regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 112 +++++++++++
 rtl/register_writeback_file.sv | 103 ++++++++++
 tb/tb_register_writeback_file.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_regfile_pkg.sv
// Shared widths and types for the architectural register file slice.
// DATA_W and PEND_MAX are set here so that every block that imports this
// package sees the same values.
package cpu_regfile_pkg;
   localparam int REG_ADDR_W = 4;
   localparam int DATA_W     = 16;
   localparam int PEND_W     = 2;
   localparam int PEND_MAX   = 3;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     word_t;
   typedef logic [PEND_W-1:0]     pend_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: per-register saturating outstanding-write
// counters, issue back-pressure, protocol error flag and operand
// availability/forwarding decisions.
// Optional feature macro: REGFILE_BYPASS_EN (forward the last outstanding
// write-back to a reader in the same cycle).
module regfile_scoreboard
   import cpu_regfile_pkg::*;
#(
   parameter int unsigned NUM_REGS = 16,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wb_en,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic                mark_en,
   input  logic [REG_ADDR_W-1:0] mark_addr,
   input  logic                rd_a_en,
   input  logic [REG_ADDR_W-1:0] rd_a_addr,
   input  logic                rd_b_en,
   input  logic [REG_ADDR_W-1:0] rd_b_addr,
   input  logic                err_clr,
   output logic                mark_ready,
   output logic [NUM_REGS-1:0] pending,
   output logic                fwd_a,
   output logic                fwd_b,
   output logic                stall,
   output logic                err
);

   pend_t               pend     [NUM_REGS];
   pend_t               pend_nxt [NUM_REGS];
   logic [NUM_REGS-1:0] inc;
   logic [NUM_REGS-1:0] dec;
   logic                err_set;
   logic                avail_a;
   logic                avail_b;

   // Decode mark and write-back strobes per register (r0 excluded when hardwired)
   always_comb begin
      inc = '0;
      dec = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (!(ZERO_REG && i == 0)) begin
            inc[i] = mark_en && (mark_addr == reg_addr_t'(i));
            dec[i] = wb_en && (wb_addr == reg_addr_t'(i));
         end
      end
   end

   // Next counter values with saturation and protocol error detection
   always_comb begin
      err_set = 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         pend_nxt[i] = pend[i];
         if (dec[i] && pend[i] == '0) begin
            err_set = 1'b1;
         end
         if (inc[i] && !dec[i]) begin
            if (pend[i] == pend_t'(PEND_MAX)) begin
               err_set = 1'b1;
            end else begin
               pend_nxt[i] = pend[i] + 1'b1;
            end
         end else if (dec[i] && !inc[i] && pend[i] != '0) begin
            pend_nxt[i] = pend[i] - 1'b1;
         end
      end
   end

   // Counter state and sticky error flag (a new error wins over err_clr)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            pend[i] <= '0;
         end
         err <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            pend[i] <= pend_nxt[i];
         end
         if (err_set) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end
      end
   end

   // Per-register pending flags
   always_comb begin
      pending = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         pending[i] = (pend[i] != '0);
      end
   end

   assign mark_ready = (pend[mark_addr] != pend_t'(PEND_MAX));

`ifdef REGFILE_BYPASS_EN
   assign fwd_a = wb_en && (wb_addr == rd_a_addr) && (pend[rd_a_addr] == pend_t'(1));
   assign fwd_b = wb_en && (wb_addr == rd_b_addr) && (pend[rd_b_addr] == pend_t'(1));
`else
   assign fwd_a = 1'b0;
   assign fwd_b = 1'b0;
`endif

   assign avail_a = !rd_a_en || (ZERO_REG && rd_a_addr == '0) || (pend[rd_a_addr] == '0) || fwd_a;
   assign avail_b = !rd_b_en || (ZERO_REG && rd_b_addr == '0) || (pend[rd_b_addr] == '0) || fwd_b;
   assign stall   = !avail_a || !avail_b;

endmodule

// File: rtl/register_writeback_file.sv
// Architectural register file fed by the register-data arbitrator, with two
// registered read ports and a pending-write scoreboard driving stall.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle forwarding of the
// last outstanding write-back, handled in regfile_scoreboard).
module register_writeback_file
   import cpu_regfile_pkg::*;
#(
   parameter int unsigned NUM_REGS = 16,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  mark_en,
   input  logic [REG_ADDR_W-1:0] mark_addr,
   output logic                  mark_ready,
   input  logic                  rd_a_en,
   input  logic [REG_ADDR_W-1:0] rd_a_addr,
   input  logic                  rd_b_en,
   input  logic [REG_ADDR_W-1:0] rd_b_addr,
   output logic [DATA_W-1:0]     rd_a_data,
   output logic [DATA_W-1:0]     rd_b_data,
   output logic                  stall,
   output logic [NUM_REGS-1:0]   pending,
   output logic                  err,
   input  logic                  err_clr
);

   word_t regs [NUM_REGS];
   word_t rd_a_val;
   word_t rd_b_val;
   logic  fwd_a;
   logic  fwd_b;

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .mark_en    (mark_en),
      .mark_addr  (mark_addr),
      .rd_a_en    (rd_a_en),
      .rd_a_addr  (rd_a_addr),
      .rd_b_en    (rd_b_en),
      .rd_b_addr  (rd_b_addr),
      .err_clr    (err_clr),
      .mark_ready (mark_ready),
      .pending    (pending),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b),
      .stall      (stall),
      .err        (err)
   );

   // Commit the arbitrated word; writes to a hardwired r0 are dropped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_en && !(ZERO_REG && wb_addr == '0)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Operand select: hardwired zero, then same-cycle write-back word
   // (covers both forwarding and write-first), then the array
   always_comb begin
      rd_a_val = regs[rd_a_addr];
      if (ZERO_REG && rd_a_addr == '0) begin
         rd_a_val = '0;
      end else if (fwd_a || (wb_en && wb_addr == rd_a_addr)) begin
         rd_a_val = wb_data;
      end
      rd_b_val = regs[rd_b_addr];
      if (ZERO_REG && rd_b_addr == '0) begin
         rd_b_val = '0;
      end else if (fwd_b || (wb_en && wb_addr == rd_b_addr)) begin
         rd_b_val = wb_data;
      end
   end

   // Registered read ports; both hold while any enabled operand is stalled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_a_data <= '0;
         rd_b_data <= '0;
      end else if (!stall) begin
         if (rd_a_en) begin
            rd_a_data <= rd_a_val;
         end
         if (rd_b_en) begin
            rd_b_data <= rd_b_val;
         end
      end
   end

endmodule

// File: tb/tb_register_writeback_file.sv
// Directed self-checking bench for register_writeback_file.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_register_writeback_file;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        mark_en;
   logic [3:0]  mark_addr;
   logic        mark_ready;
   logic        rd_a_en;
   logic [3:0]  rd_a_addr;
   logic        rd_b_en;
   logic [3:0]  rd_b_addr;
   logic [15:0] rd_a_data;
   logic [15:0] rd_b_data;
   logic        stall;
   logic [15:0] pending;
   logic        err;
   logic        err_clr;

   int n_checks = 0;
   int n_fail   = 0;

   register_writeback_file #(
      .NUM_REGS (16),
      .ZERO_REG (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .mark_en    (mark_en),
      .mark_addr  (mark_addr),
      .mark_ready (mark_ready),
      .rd_a_en    (rd_a_en),
      .rd_a_addr  (rd_a_addr),
      .rd_b_en    (rd_b_en),
      .rd_b_addr  (rd_b_addr),
      .rd_a_data  (rd_a_data),
      .rd_b_data  (rd_b_data),
      .stall      (stall),
      .pending    (pending),
      .err        (err),
      .err_clr    (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset;
      #2;
      n_checks++; if (rd_a_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_a: got %h expected %h", rd_a_data, 16'h0000); end
      n_checks++; if (rd_b_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_b: got %h expected %h", rd_b_data, 16'h0000); end
      n_checks++; if (pending !== 16'h0000) begin n_fail++; $display("FAIL reset_pending: got %h expected %h", pending, 16'h0000); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected %b", err, 1'b0); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected %b", stall, 1'b0); end
      n_checks++; if (mark_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mark_ready: got %b expected %b", mark_ready, 1'b1); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_write_read;
      wb_en = 1'b1; wb_addr = 4'd5; wb_data = 16'hBEEF;
      @(negedge clk);
      wb_en = 1'b0; rd_a_en = 1'b1; rd_a_addr = 4'd5;
      #1;
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL wr_unmarked_err: got %b expected %b", err, 1'b1); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wr_read_stall: got %b expected %b", stall, 1'b0); end
      @(negedge clk);
      rd_a_en = 1'b0;
      n_checks++; if (rd_a_data !== 16'hBEEF) begin n_fail++; $display("FAIL wr_read_data: got %h expected %h", rd_a_data, 16'hBEEF); end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err_clr: got %b expected %b", err, 1'b0); end
   endtask

   task automatic test_stall;
      mark_en = 1'b1; mark_addr = 4'd3;
      #1;
      n_checks++; if (mark_ready !== 1'b1) begin n_fail++; $display("FAIL stall_mark_ready: got %b expected %b", mark_ready, 1'b1); end
      @(negedge clk);
      mark_en = 1'b0;
      n_checks++; if (pending !== 16'h0008) begin n_fail++; $display("FAIL stall_pending_set: got %h expected %h", pending, 16'h0008); end
      rd_a_en = 1'b1; rd_a_addr = 4'd3;
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_asserted: got %b expected %b", stall, 1'b1); end
      @(negedge clk);
      n_checks++; if (rd_a_data !== 16'hBEEF) begin n_fail++; $display("FAIL stall_hold: got %h expected %h", rd_a_data, 16'hBEEF); end
      wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'h1234;
      #1;
      n_checks++; if (stall !== !BYP) begin n_fail++; $display("FAIL stall_wb_cycle: got %b expected %b", stall, !BYP); end
      @(negedge clk);
      wb_en = 1'b0;
      n_checks++; if (pending !== 16'h0000) begin n_fail++; $display("FAIL stall_pending_clr: got %h expected %h", pending, 16'h0000); end
      n_checks++; if (rd_a_data !== (BYP ? 16'h1234 : 16'hBEEF)) begin n_fail++; $display("FAIL stall_fwd_data: got %h expected %h", rd_a_data, (BYP ? 16'h1234 : 16'hBEEF)); end
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_released: got %b expected %b", stall, 1'b0); end
      @(negedge clk);
      rd_a_en = 1'b0;
      n_checks++; if (rd_a_data !== 16'h1234) begin n_fail++; $display("FAIL stall_read_after: got %h expected %h", rd_a_data, 16'h1234); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL stall_no_err: got %b expected %b", err, 1'b0); end
   endtask

   task automatic test_saturation;
      mark_en = 1'b1; mark_addr = 4'd7;
      repeat (3) @(negedge clk);
      n_checks++; if (mark_ready !== 1'b0) begin n_fail++; $display("FAIL sat_mark_ready: got %b expected %b", mark_ready, 1'b0); end
      n_checks++; if (pending !== 16'h0080) begin n_fail++; $display("FAIL sat_pending: got %h expected %h", pending, 16'h0080); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sat_no_err_yet: got %b expected %b", err, 1'b0); end
      @(negedge clk);
      mark_en = 1'b0;
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL sat_overflow_err: got %b expected %b", err, 1'b1); end
      n_checks++; if (mark_ready !== 1'b0) begin n_fail++; $display("FAIL sat_count_held: got %b expected %b", mark_ready, 1'b0); end
      wb_en = 1'b1; wb_addr = 4'd7; wb_data = 16'h0707;
      repeat (2) @(negedge clk);
      n_checks++; if (pending !== 16'h0080) begin n_fail++; $display("FAIL sat_one_left: got %h expected %h", pending, 16'h0080); end
      @(negedge clk);
      wb_en = 1'b0;
      n_checks++; if (pending !== 16'h0000) begin n_fail++; $display("FAIL sat_drained: got %h expected %h", pending, 16'h0000); end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL sat_err_sticky: got %b expected %b", err, 1'b1); end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sat_err_clr: got %b expected %b", err, 1'b0); end
      n_checks++; if (mark_ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready_again: got %b expected %b", mark_ready, 1'b1); end
   endtask

   task automatic test_simultaneous;
      mark_en = 1'b1; mark_addr = 4'd2;
      @(negedge clk);
      wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'h2222;
      @(negedge clk);
      mark_en = 1'b0; wb_en = 1'b0;
      n_checks++; if (pending !== 16'h0004) begin n_fail++; $display("FAIL simul_pending: got %h expected %h", pending, 16'h0004); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL simul_no_err: got %b expected %b", err, 1'b0); end
      rd_a_en = 1'b1; rd_a_addr = 4'd2;
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL simul_stall: got %b expected %b", stall, 1'b1); end
      @(negedge clk);
      rd_a_en = 1'b0;
      n_checks++; if (rd_a_data !== 16'h1234) begin n_fail++; $display("FAIL simul_hold: got %h expected %h", rd_a_data, 16'h1234); end
      wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'h3333;
      @(negedge clk);
      wb_en = 1'b0;
      n_checks++; if (pending !== 16'h0000) begin n_fail++; $display("FAIL simul_drained: got %h expected %h", pending, 16'h0000); end
      rd_a_en = 1'b1; rd_a_addr = 4'd2;
      @(negedge clk);
      rd_a_en = 1'b0;
      n_checks++; if (rd_a_data !== 16'h3333) begin n_fail++; $display("FAIL simul_read: got %h expected %h", rd_a_data, 16'h3333); end
   endtask

   task automatic test_zero_reg;
      wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;
      @(negedge clk);
      wb_en = 1'b0;
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL zero_wr_no_err: got %b expected %b", err, 1'b0); end
      rd_a_en = 1'b1; rd_a_addr = 4'd0;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %b expected %b", stall, 1'b0); end
      @(negedge clk);
      rd_a_en = 1'b0;
      n_checks++; if (rd_a_data !== 16'h0000) begin n_fail++; $display("FAIL zero_read: got %h expected %h", rd_a_data, 16'h0000); end
      mark_en = 1'b1; mark_addr = 4'd0;
      @(negedge clk);
      mark_en = 1'b0;
      n_checks++; if (pending !== 16'h0000) begin n_fail++; $display("FAIL zero_mark_ignored: got %h expected %h", pending, 16'h0000); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL zero_mark_no_err: got %b expected %b", err, 1'b0); end
   endtask

   task automatic test_back_to_back;
      wb_en = 1'b1; wb_addr = 4'd9; wb_data = 16'h9999;
      @(negedge clk);
      wb_en = 1'b0;
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL b2b_unexpected_err: got %b expected %b", err, 1'b1); end
      mark_en = 1'b1; mark_addr = 4'd1;
      @(negedge clk);
      mark_en = 1'b0;
      n_checks++; if (pending !== 16'h0002) begin n_fail++; $display("FAIL b2b_pending: got %h expected %h", pending, 16'h0002); end
      rd_a_en = 1'b1; rd_a_addr = 4'd9;
      rd_b_en = 1'b1; rd_b_addr = 4'd1;
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall: got %b expected %b", stall, 1'b1); end
      @(negedge clk);
      n_checks++; if (rd_a_data !== 16'h0000) begin n_fail++; $display("FAIL b2b_hold_a: got %h expected %h", rd_a_data, 16'h0000); end
      n_checks++; if (rd_b_data !== 16'h0000) begin n_fail++; $display("FAIL b2b_hold_b: got %h expected %h", rd_b_data, 16'h0000); end
      wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'h1111;
      #1;
      n_checks++; if (stall !== !BYP) begin n_fail++; $display("FAIL b2b_wb_stall: got %b expected %b", stall, !BYP); end
      @(negedge clk);
      wb_en = 1'b0;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_released: got %b expected %b", stall, 1'b0); end
      @(negedge clk);
      rd_a_en = 1'b0; rd_b_en = 1'b0;
      n_checks++; if (rd_a_data !== 16'h9999) begin n_fail++; $display("FAIL b2b_read_a: got %h expected %h", rd_a_data, 16'h9999); end
      n_checks++; if (rd_b_data !== 16'h1111) begin n_fail++; $display("FAIL b2b_read_b: got %h expected %h", rd_b_data, 16'h1111); end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic test_reset_mid;
      mark_en = 1'b1; mark_addr = 4'd6;
      wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'h4444;
      @(negedge clk);
      mark_en = 1'b0; wb_en = 1'b0;
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL mid_err_set: got %b expected %b", err, 1'b1); end
      n_checks++; if (pending !== 16'h0040) begin n_fail++; $display("FAIL mid_pending_set: got %h expected %h", pending, 16'h0040); end
      #2;
      rst = 1'b0;
      #1;
      n_checks++; if (rd_a_data !== 16'h0000) begin n_fail++; $display("FAIL mid_rd_a: got %h expected %h", rd_a_data, 16'h0000); end
      n_checks++; if (rd_b_data !== 16'h0000) begin n_fail++; $display("FAIL mid_rd_b: got %h expected %h", rd_b_data, 16'h0000); end
      n_checks++; if (pending !== 16'h0000) begin n_fail++; $display("FAIL mid_pending: got %h expected %h", pending, 16'h0000); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b expected %b", err, 1'b0); end
      @(negedge clk);
      rst = 1'b1;
      rd_a_en = 1'b1; rd_a_addr = 4'd4;
      rd_b_en = 1'b1; rd_b_addr = 4'd9;
      @(negedge clk);
      rd_a_en = 1'b0; rd_b_en = 1'b0;
      n_checks++; if (rd_a_data !== 16'h0000) begin n_fail++; $display("FAIL mid_r4_cleared: got %h expected %h", rd_a_data, 16'h0000); end
      n_checks++; if (rd_b_data !== 16'h0000) begin n_fail++; $display("FAIL mid_r9_cleared: got %h expected %h", rd_b_data, 16'h0000); end
   endtask

   initial begin
      rst       = 1'b0;
      wb_en     = 1'b0; wb_addr   = '0; wb_data = '0;
      mark_en   = 1'b0; mark_addr = '0;
      rd_a_en   = 1'b0; rd_a_addr = '0;
      rd_b_en   = 1'b0; rd_b_addr = '0;
      err_clr   = 1'b0;
      test_reset();
      test_write_read();
      test_stall();
      test_saturation();
      test_simultaneous();
      test_zero_reg();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
